gpio_port: RTL and testbench

//  Memory-mapped GPIO responder on the cpu data bus; the far end of the gpio pins the cpu drives.

---
 rtl/gpio_port_pkg.sv | 9 +
 rtl/gpio_sync.sv | 25 ++
 rtl/gpio_port.sv | 96 +++++++++
 tb/tb_gpio_port.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/gpio_port_pkg.sv
// Shared register map for the GPIO responder.
package gpio_port_pkg;

    localparam logic [1:0] GPIO_OUT   = 2'd0;
    localparam logic [1:0] GPIO_IN    = 2'd1;
    localparam logic [1:0] GPIO_EDGE  = 2'd2;
    localparam logic [1:0] GPIO_IRQEN = 2'd3;

endpackage

// File: rtl/gpio_sync.sv
// Multi-bit flop-chain synchronizer for asynchronous input pins.
module gpio_sync #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [STAGES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) chain[i] <= '0;
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/gpio_port.sv
// Memory-mapped GPIO responder: output latch, synchronized input, sticky
// rising-edge status with write-1-to-clear, and a masked level interrupt.
module gpio_port
    import gpio_port_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sel,
    input  logic                  we,
    input  logic [1:0]            addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    input  logic [DATA_WIDTH-1:0] gpio_in,
    output logic [DATA_WIDTH-1:0] gpio_out,
    output logic                  irq
);

    localparam int ARM_MAX = SYNC_STAGES + 1;
    localparam int ARM_W   = $clog2(ARM_MAX + 1);

    logic [DATA_WIDTH-1:0] out_reg, edge_reg, irqen_reg;
    logic [DATA_WIDTH-1:0] in_s, in_d;
    logic [DATA_WIDTH-1:0] rise, clr, edge_next, irqen_next, out_next, rd_mux;
    logic [ARM_W-1:0]      arm_cnt;
    logic                  armed, wr, rd;

    gpio_sync #(.WIDTH(DATA_WIDTH), .STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (gpio_in),
        .q     (in_s)
    );

    assign wr    = sel & we;
    assign rd    = sel & ~we;
    // Edges are suppressed until the chain and in_d hold real pin history,
    // so pins already high at reset release do not look like rising edges.
    assign armed = (arm_cnt == ARM_W'(ARM_MAX));
    assign rise  = in_s & ~in_d & {DATA_WIDTH{armed}};

    always_comb begin
        clr        = '0;
        out_next   = out_reg;
        irqen_next = irqen_reg;
        if (wr) begin
            case (addr)
                GPIO_OUT:   out_next   = wdata;
                GPIO_EDGE:  clr        = wdata;
                GPIO_IRQEN: irqen_next = wdata;
                default:    ;
            endcase
        end
        // Set wins over a simultaneous clear on the same bit.
        edge_next = (edge_reg & ~clr) | rise;
    end

    always_comb begin
        rd_mux = '0;
        case (addr)
            GPIO_OUT:   rd_mux = out_reg;
            GPIO_IN:    rd_mux = in_s;
            GPIO_EDGE:  rd_mux = edge_reg;
            GPIO_IRQEN: rd_mux = irqen_reg;
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_reg   <= '0;
            edge_reg  <= '0;
            irqen_reg <= '0;
            in_d      <= '0;
            arm_cnt   <= '0;
            rdata     <= '0;
            rvalid    <= 1'b0;
            irq       <= 1'b0;
        end else begin
            out_reg   <= out_next;
            edge_reg  <= edge_next;
            irqen_reg <= irqen_next;
            in_d      <= in_s;
            if (!armed) arm_cnt <= arm_cnt + 1'b1;
            rvalid    <= rd;
            if (rd) rdata <= rd_mux;
            irq       <= |(edge_next & irqen_next);
        end
    end

    assign gpio_out = out_reg;

endmodule

// File: tb/tb_gpio_port.sv
// Self-checking bench for gpio_port: per-cycle reference model plus directed
// register-access scenarios with hand-computed expectations.
module tb_gpio_port;

    localparam int DW   = 32;
    localparam int SYNC = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          sel, we;
    logic [1:0]    addr;
    logic [DW-1:0] wdata, rdata, gpio_in, gpio_out;
    logic          rvalid, irq;

    int n_checks = 0;
    int n_pass   = 0;

    gpio_port #(.DATA_WIDTH(DW), .SYNC_STAGES(SYNC)) dut (
        .clk      (clk),
        .reset    (reset),
        .sel      (sel),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    // Reference model. A pin value becomes readable SYNC edges after it is
    // sampled; a rise is "seen SYNC edges ago high, SYNC+1 edges ago low",
    // and is only recorded once SYNC+1 edges have passed since reset.
    bit [DW-1:0] m_out, m_edge, m_irqen, m_rdata, m_rise, m_clr;
    bit          m_rvalid, m_irq;
    bit [DW-1:0] hist [0:SYNC];
    int          since_rst;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_out = '0; m_edge = '0; m_irqen = '0; m_rdata = '0;
            m_rvalid = 1'b0; m_irq = 1'b0; since_rst = 0;
            for (int i = 0; i <= SYNC; i++) hist[i] = '0;
        end else begin
            m_rise = (since_rst >= SYNC + 1) ? (hist[SYNC-1] & ~hist[SYNC]) : '0;
            m_rvalid = sel && !we;
            if (sel && !we) begin
                case (addr)
                    2'd0: m_rdata = m_out;
                    2'd1: m_rdata = hist[SYNC-1];
                    2'd2: m_rdata = m_edge;
                    default: m_rdata = m_irqen;
                endcase
            end
            m_clr = '0;
            if (sel && we) begin
                case (addr)
                    2'd0: m_out = wdata;
                    2'd2: m_clr = wdata;
                    2'd3: m_irqen = wdata;
                    default: ;
                endcase
            end
            m_edge = (m_edge & ~m_clr) | m_rise;
            m_irq  = |(m_edge & m_irqen);
            for (int i = SYNC; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = gpio_in;
            if (since_rst < 1000) since_rst++;
        end
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        check("model rdata",    rdata,            m_rdata);
        check("model rvalid",   {31'd0, rvalid},  {31'd0, m_rvalid});
        check("model gpio_out", gpio_out,         m_out);
        check("model irq",      {31'd0, irq},     {31'd0, m_irq});
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [DW-1:0] d);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        sel = 1'b0; we = 1'b0; wdata = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, input logic [DW-1:0] exp, input string name);
        sel = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        sel = 1'b0;
        check({name, " rvalid"}, {31'd0, rvalid}, 32'd1);
        check(name, rdata, exp);
    endtask

    initial begin
        reset = 1'b1; sel = 1'b0; we = 1'b0; addr = 2'd0; wdata = '0;
        gpio_in = 32'hFFFF_FFFF;
        cycles(3);
        reset = 1'b0;

        // 1: pins high through reset release must not fire
        cycles(10);
        check("arm irq", {31'd0, irq}, 32'd0);
        bus_read(2'd2, 32'h0, "arm EDGE");
        bus_read(2'd1, 32'hFFFF_FFFF, "arm IN");
        gpio_in = 32'h0;
        cycles(4);

        // 2: OUT write/readback, IN is read-only
        bus_write(2'd0, 32'hA5A5_0F0F);
        check("gpio_out", gpio_out, 32'hA5A5_0F0F);
        bus_read(2'd0, 32'hA5A5_0F0F, "read OUT");
        cycles(1);
        check("rvalid idle", {31'd0, rvalid}, 32'd0);
        check("rdata hold", rdata, 32'hA5A5_0F0F);
        bus_write(2'd1, 32'h0000_1234);
        bus_read(2'd1, 32'h0, "IN after write");

        // 3: rising edge on bit0 with IRQEN=1, then W1C
        bus_write(2'd3, 32'h1);
        gpio_in = 32'h1;
        cycles(2);
        check("irq before latency", {31'd0, irq}, 32'd0);
        cycles(1);
        check("irq after latency", {31'd0, irq}, 32'd1);
        bus_read(2'd2, 32'h1, "EDGE bit0");
        bus_write(2'd2, 32'h1);
        check("irq after W1C", {31'd0, irq}, 32'd0);
        bus_read(2'd2, 32'h0, "EDGE cleared");

        // 4: W1C coinciding with a fresh rise keeps the bit
        bus_write(2'd3, 32'h10);
        gpio_in = 32'h11;
        cycles(4);
        bus_read(2'd2, 32'h10, "EDGE bit4");
        gpio_in = 32'h01;
        cycles(4);
        gpio_in = 32'h11;
        cycles(2);
        bus_write(2'd2, 32'h10);
        check("set wins irq", {31'd0, irq}, 32'd1);
        bus_read(2'd2, 32'h10, "set wins EDGE");

        // 5: falling edges ignored, masked status, late enable
        bus_write(2'd3, 32'h0);
        bus_write(2'd2, 32'hFFFF_FFFF);
        gpio_in = 32'h15;
        cycles(4);
        bus_write(2'd2, 32'h4);
        gpio_in = 32'h11;
        cycles(4);
        bus_read(2'd2, 32'h0, "fall ignored");
        gpio_in = 32'h19;
        cycles(4);
        bus_read(2'd2, 32'h8, "EDGE bit3");
        check("masked irq", {31'd0, irq}, 32'd0);
        bus_write(2'd3, 32'h8);
        check("enabled irq", {31'd0, irq}, 32'd1);

        // 6: async reset during a read with state nonzero
        bus_write(2'd0, 32'hDEAD_BEEF);
        gpio_in = 32'hFFFF_FFFF;
        cycles(4);
        sel = 1'b1; we = 1'b0; addr = 2'd2;
        #2 reset = 1'b1;
        #1;
        check("rst gpio_out", gpio_out, 32'h0);
        check("rst irq", {31'd0, irq}, 32'd0);
        check("rst rvalid", {31'd0, rvalid}, 32'd0);
        check("rst rdata", rdata, 32'h0);
        sel = 1'b0;
        cycles(2);
        reset = 1'b0;
        cycles(10);
        check("rearm irq", {31'd0, irq}, 32'd0);
        bus_read(2'd2, 32'h0, "rearm EDGE");
        bus_read(2'd1, 32'hFFFF_FFFF, "rearm IN");
        cycles(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
